pipe_skid_reg: RTL and testbench

- Generic parametrised pipeline-stage register that replaces the hand-built per-stage registers between IF/ID/EX/MEM/WB.
- Carries an arbitrary-width payload with a full valid/ready handshake on both sides, plus synchronous flush and external stall.
- Adds a one-entry skid buffer so `in_ready` is a pure register output, with no combinational path from `out_ready`.
- Supports full throughput: one transfer per cycle in steady state.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_data_reg.sv | 27 ++
 rtl/pipe_skid_reg.sv | 104 ++++++++++
 tb/tb_pipe_skid_reg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: skid FSM states and
// payload widths of the inter-stage registers.
package pipe_pkg;

    localparam logic [1:0] ENC_EMPTY = 2'd0;
    localparam logic [1:0] ENC_BUSY  = 2'd1;
    localparam logic [1:0] ENC_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ENC_EMPTY,
        BUSY  = ENC_BUSY,
        FULL  = ENC_FULL
    } skid_state_t;

    localparam int unsigned IF_ID_W  = 64;
    localparam int unsigned ID_EX_W  = 128;
    localparam int unsigned EX_MEM_W = 96;
    localparam int unsigned MEM_WB_W = 72;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable; reset and synchronous clear both
// return it to RESET_DATA.
module pipe_data_reg #(
    parameter int unsigned              DATA_W     = 64,
    parameter logic [DATA_W-1:0]        RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_q <= RESET_DATA;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready on both sides and a one-entry
// skid buffer so in_ready is driven only from state and rst_n.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    skid_state_t       r_state;
    skid_state_t       w_state_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_en;
    logic              w_main_from_skid;
    logic              w_skid_en;
    logic [DATA_W-1:0] w_main_d;
    logic [DATA_W-1:0] w_main_q;
    logic [DATA_W-1:0] w_skid_q;

    assign out_valid  = (r_state != EMPTY);
    assign in_ready   = rst_n & (r_state != FULL);
    assign occupancy  = r_state;
    assign out_data   = w_main_q;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready & ~stall;
    assign w_main_d   = w_main_from_skid ? w_skid_q : in_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_en        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_en        = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_main_en   = 1'b1;
                        w_state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_en = 1'b1;
                    end else if (w_in_fire) begin
                        w_skid_en   = 1'b1;
                        w_state_nxt = FULL;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_main_en        = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = BUSY;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    pipe_data_reg #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_en  (w_main_en),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    pipe_data_reg #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_en  (w_skid_en),
        .i_d   (in_data),
        .o_q   (w_skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, skid backpressure,
// stall, flush and mid-stream reset with hand-computed expectations.
module tb_pipe_skid_reg;

    localparam int unsigned       DW = 16;
    localparam logic [DW-1:0]     RD = 16'h5A5A;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          stall;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .RESET_DATA(RD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b1; in_data = 16'hAAAA; out_ready = 1'b0;
        settle();
        chk("rst_in_ready_low", {15'b0, in_ready}, 16'd0);

        // 1. reset held two cycles with input offered
        tick();
        tick();
        chk("rst_in_ready",  {15'b0, in_ready},  16'd0);
        chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
        chk("rst_occ",       {14'b0, occupancy}, 16'd0);
        chk("rst_out_data",  out_data,           RD);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        settle();
        chk("rel_in_ready",  {15'b0, in_ready},  16'd1);

        // 2. streaming at full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = DW'(i);
            settle();
            chk("str_in_ready", {15'b0, in_ready}, 16'd1);
            tick();
            chk("str_out_valid", {15'b0, out_valid}, 16'd1);
            chk("str_out_data",  out_data,           DW'(i));
            chk("str_occ",       {14'b0, occupancy}, 16'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("str_drain_occ", {14'b0, occupancy}, 16'd0);

        // 3. backpressure into the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0010;
        tick();
        chk("bp_occ1",  {14'b0, occupancy}, 16'd1);
        in_data = 16'h0011;
        tick();
        chk("bp_occ2",      {14'b0, occupancy}, 16'd2);
        chk("bp_in_ready0", {15'b0, in_ready},  16'd0);
        chk("bp_hold_data", out_data,           16'h0010);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("bp_first", out_data, 16'h0010);
        tick();
        chk("bp_second",    out_data,           16'h0011);
        chk("bp_in_ready1", {15'b0, in_ready},  16'd1);
        chk("bp_occ_back1", {14'b0, occupancy}, 16'd1);
        tick();
        chk("bp_empty", {15'b0, out_valid}, 16'd0);

        // 4. stall holds the output while input fills the skid
        stall    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0020;
        tick();
        chk("st_busy_data", out_data, 16'h0020);
        in_data = 16'h0021;
        tick();
        chk("st_data_c2", out_data,           16'h0020);
        chk("st_occ2",    {14'b0, occupancy}, 16'd2);
        in_valid = 1'b0;
        tick();
        chk("st_data_c3",  out_data,           16'h0020);
        chk("st_valid_c3", {15'b0, out_valid}, 16'd1);
        chk("st_occ_c3",   {14'b0, occupancy}, 16'd2);
        stall = 1'b0;
        settle();
        chk("st_rel_first", out_data, 16'h0020);
        tick();
        chk("st_rel_second", out_data,           16'h0021);
        chk("st_rel_occ",    {14'b0, occupancy}, 16'd1);
        tick();
        chk("st_empty", {15'b0, out_valid}, 16'd0);

        // 5. flush from FULL, then flush with an accepted beat
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0030;
        tick();
        in_data = 16'h0031;
        tick();
        chk("fl_full", {14'b0, occupancy}, 16'd2);
        flush   = 1'b1;
        in_data = 16'h0032;
        tick();
        chk("fl_valid", {15'b0, out_valid}, 16'd0);
        chk("fl_occ",   {14'b0, occupancy}, 16'd0);
        chk("fl_data",  out_data,           RD);
        chk("fl_ready", {15'b0, in_ready},  16'd1);
        in_data = 16'h0033;
        tick();
        chk("fl_drop_valid", {15'b0, out_valid}, 16'd0);
        chk("fl_drop_data",  out_data,           RD);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_after_valid", {15'b0, out_valid}, 16'd0);
        chk("fl_after_data",  out_data,           RD);

        // 6. reset while an entry is held, then resume
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0035;
        tick();
        chk("mr_busy", {14'b0, occupancy}, 16'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("mr_valid", {15'b0, out_valid}, 16'd0);
        chk("mr_occ",   {14'b0, occupancy}, 16'd0);
        chk("mr_data",  out_data,           RD);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0040;
        tick();
        chk("mr_resume_valid", {15'b0, out_valid}, 16'd1);
        chk("mr_resume_data",  out_data,           16'h0040);
        in_valid = 1'b0;
        tick();
        chk("mr_final_occ", {14'b0, occupancy}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
